gmii_rx_framer: RTL

//  Upstream stage of the Ethernet receive DMA path. Takes GMII receive bytes and strips preamble/SFD.

---
 rtl/gmii_rx_framer.sv | 304 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, prepends a 64-bit timestamp and packs bytes into
// 18-bit Phy FIFO words, then posts one length/status word. Define RX_CRC_CHECK_EN to add FCS checking.
module gmii_rx_framer #(
    parameter logic [10:0] MAX_FRAME  = 11'd1518,
    parameter int          DROP_CNT_W = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  gmii_rx_dv,
    input  logic                  gmii_rx_er,
    input  logic [7:0]            gmii_rxd,
    output logic [17:0]           phy_din,
    output logic                  phy_wr_en,
    input  logic                  phy_afull,
    output logic [17:0]           len_din,
    output logic                  len_wr_en,
    input  logic                  len_full,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_HDR   = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;
    localparam logic [2:0] S_LEN   = 3'd5;
    localparam logic [2:0] S_TRUNC = 3'd6;
    localparam logic [2:0] S_DROP  = 3'd7;

    logic [2:0]            state_q, state_d;
    logic                  arm_q, arm_d;
    logic [63:0]           gcnt_q, gcnt_d;
    logic [63:0]           ts_q, ts_d;
    logic [1:0]            hdr_idx_q, hdr_idx_d;
    logic [10:0]           byte_cnt_q, byte_cnt_d;
    logic [7:0]            hi_byte_q, hi_byte_d;
    logic                  have_hi_q, have_hi_d;
    logic                  eof_q, eof_d;
    logic                  err_q, err_d;
    logic                  trunc_q, trunc_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [17:0]           phy_din_q, phy_din_d;
    logic                  phy_wr_en_q, phy_wr_en_d;
    logic [17:0]           len_din_q, len_din_d;
    logic                  len_wr_en_q, len_wr_en_d;
    logic [15:0]           q_mem_q [3];
    logic [15:0]           q_mem_d [3];
    logic [15:0]           q_shift [3];
    logic [1:0]            q_cnt_q, q_cnt_d;
    logic [1:0]            q_after;

    logic                  take;
    logic                  eof_now;
    logic                  trunc_now;
    logic                  push;
    logic [15:0]           push_word;
    logic                  pop;
    logic                  final_w;
    logic [15:0]           ts_word;
    logic                  crc_bad;

    genvar gi;

    always_comb begin
        ts_word = ts_q[63:48];
        case (hdr_idx_q)
            2'd0:    ts_word = ts_q[63:48];
            2'd1:    ts_word = ts_q[47:32];
            2'd2:    ts_word = ts_q[31:16];
            default: ts_word = ts_q[15:0];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        arm_d       = arm_q | ~gmii_rx_dv;
        gcnt_d      = gcnt_q + 64'd1;
        ts_d        = ts_q;
        hdr_idx_d   = hdr_idx_q;
        byte_cnt_d  = byte_cnt_q;
        hi_byte_d   = hi_byte_q;
        have_hi_d   = have_hi_q;
        eof_d       = eof_q;
        err_d       = err_q;
        trunc_d     = trunc_q;
        drop_cnt_d  = drop_cnt_q;
        phy_din_d   = phy_din_q;
        phy_wr_en_d = 1'b0;
        len_din_d   = len_din_q;
        len_wr_en_d = 1'b0;
        take        = 1'b0;
        eof_now     = 1'b0;
        trunc_now   = 1'b0;
        push        = 1'b0;
        push_word   = 16'h0000;
        pop         = 1'b0;
        final_w     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arm_q && gmii_rx_dv) state_d = S_PRE;
            end
            S_PRE: begin
                if (!gmii_rx_dv) begin
                    state_d = S_IDLE;
                end else if (gmii_rxd == 8'hD5) begin
                    if (phy_afull || len_full) begin
                        state_d = S_DROP;
                        if (drop_cnt_q != {DROP_CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + 1'b1;
                    end else begin
                        state_d    = S_HDR;
                        ts_d       = gcnt_q;
                        hdr_idx_d  = 2'd0;
                        byte_cnt_d = 11'd0;
                        have_hi_d  = 1'b0;
                        eof_d      = 1'b0;
                        err_d      = 1'b0;
                        trunc_d    = 1'b0;
                    end
                end else if (gmii_rxd != 8'h55) begin
                    // Mid-frame garbage: wait for rx_dv to drop before hunting again.
                    state_d = S_IDLE;
                    arm_d   = 1'b0;
                end
            end
            S_HDR: begin
                phy_wr_en_d = 1'b1;
                phy_din_d   = {2'b11, ts_word};
                hdr_idx_d   = hdr_idx_q + 2'd1;
                if (!eof_q) begin
                    if (gmii_rx_dv) take = 1'b1;
                    else            eof_now = 1'b1;
                end
                if (hdr_idx_q == 2'd3) begin
                    if ((eof_q || eof_now) && (q_cnt_q == 2'd0) && !have_hi_q) begin
                        phy_din_d[16] = 1'b0;
                        state_d       = S_LEN;
                    end else if (eof_q || eof_now) begin
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (!gmii_rx_dv) begin
                    eof_now = 1'b1;
                    state_d = S_FLUSH;
                end else if (phy_afull || (byte_cnt_q == MAX_FRAME)) begin
                    trunc_now = 1'b1;
                    trunc_d   = 1'b1;
                    err_d     = 1'b1;
                    state_d   = S_FLUSH;
                end else begin
                    take = 1'b1;
                end
            end
            S_FLUSH: begin
                if (q_cnt_q == 2'd0) state_d = S_LEN;
            end
            S_LEN: begin
                len_wr_en_d = 1'b1;
                len_din_d   = {1'b1, err_q, 5'b00000, byte_cnt_q + 11'd8};
                state_d     = trunc_q ? S_TRUNC : S_IDLE;
                arm_d       = ~gmii_rx_dv;
            end
            S_TRUNC, S_DROP: begin
                if (!gmii_rx_dv) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (take) begin
            byte_cnt_d = byte_cnt_q + 11'd1;
            if (gmii_rx_er) err_d = 1'b1;
            if (have_hi_q) begin
                push      = 1'b1;
                push_word = {hi_byte_q, gmii_rxd};
                have_hi_d = 1'b0;
            end else begin
                hi_byte_d = gmii_rxd;
                have_hi_d = 1'b1;
            end
        end

        if (eof_now || trunc_now) begin
            eof_d = 1'b1;
            if (have_hi_q) begin
                push      = 1'b1;
                push_word = {hi_byte_q, 8'h00};
                have_hi_d = 1'b0;
            end
        end
        if (eof_now && crc_bad) err_d = 1'b1;

        // The newest word is held back until EOF is known so it can carry the last tag.
        pop = ((state_q == S_DATA) || (state_q == S_FLUSH)) &&
              ((q_cnt_q >= 2'd2) || (eof_q && (q_cnt_q != 2'd0)));
        if (pop) begin
            final_w     = eof_q && (q_cnt_q == 2'd1) && !push;
            phy_wr_en_d = 1'b1;
            phy_din_d   = {1'b1, ~final_w, q_mem_q[0]};
            if (final_w) state_d = S_LEN;
        end
    end

    assign q_after = q_cnt_q - {1'b0, pop};
    assign q_cnt_d = q_after + {1'b0, push};

    generate
        for (gi = 0; gi < 3; gi++) begin : g_queue
            if (gi < 2) begin : g_shift
                assign q_shift[gi] = q_mem_q[gi+1];
            end else begin : g_last
                assign q_shift[gi] = q_mem_q[gi];
            end
            assign q_mem_d[gi] = (push && (q_after == 2'(gi))) ? push_word :
                                 (pop ? q_shift[gi] : q_mem_q[gi]);
        end
    endgenerate

`ifdef RX_CRC_CHECK_EN
    logic [31:0] crc_q, crc_d, crc_rev;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h000000, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    always_comb begin
        crc_d = crc_q;
        if (state_q == S_PRE) crc_d = 32'hFFFF_FFFF;
        else if (take)        crc_d = crc32_byte(crc_q, gmii_rxd);
    end

    // The shift register runs LSB-first, so the residue is compared bit-reversed.
    generate
        for (gi = 0; gi < 32; gi++) begin : g_crc_rev
            assign crc_rev[gi] = crc_q[31-gi];
        end
    endgenerate
    assign crc_bad = (crc_rev != 32'hC704DD7B);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) crc_q <= 32'hFFFF_FFFF;
        else            crc_q <= crc_d;
    end
`else
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            arm_q       <= 1'b0;
            gcnt_q      <= 64'd0;
            ts_q        <= 64'd0;
            hdr_idx_q   <= 2'd0;
            byte_cnt_q  <= 11'd0;
            hi_byte_q   <= 8'h00;
            have_hi_q   <= 1'b0;
            eof_q       <= 1'b0;
            err_q       <= 1'b0;
            trunc_q     <= 1'b0;
            drop_cnt_q  <= '0;
            phy_din_q   <= 18'd0;
            phy_wr_en_q <= 1'b0;
            len_din_q   <= 18'd0;
            len_wr_en_q <= 1'b0;
            q_mem_q     <= '{default: '0};
            q_cnt_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            arm_q       <= arm_d;
            gcnt_q      <= gcnt_d;
            ts_q        <= ts_d;
            hdr_idx_q   <= hdr_idx_d;
            byte_cnt_q  <= byte_cnt_d;
            hi_byte_q   <= hi_byte_d;
            have_hi_q   <= have_hi_d;
            eof_q       <= eof_d;
            err_q       <= err_d;
            trunc_q     <= trunc_d;
            drop_cnt_q  <= drop_cnt_d;
            phy_din_q   <= phy_din_d;
            phy_wr_en_q <= phy_wr_en_d;
            len_din_q   <= len_din_d;
            len_wr_en_q <= len_wr_en_d;
            q_mem_q     <= q_mem_d;
            q_cnt_q     <= q_cnt_d;
        end
    end

    assert property (@(posedge sys_clk) disable iff (!sys_rst_n) !(push && !pop && (q_cnt_q == 2'd3)));

    assign phy_din   = phy_din_q;
    assign phy_wr_en = phy_wr_en_q;
    assign len_din   = len_din_q;
    assign len_wr_en = len_wr_en_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
